// File: rtl/ws_array_ctrl_if.sv
// Signal bundle between the NPU command front-end / array-side memories and the
// weight-stationary array sequencer.
interface ws_array_ctrl_if #(
    parameter int N     = 4,
    parameter int VEC_W = 8
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    logic             start_i;
    logic             reload_w_i;
    logic [VEC_W-1:0] num_vec_i;
    logic             busy_o;
    logic             done_o;
    logic             w_rd_en_o;
    logic [AW-1:0]    w_rd_addr_o;
    logic [N-1:0]     load_en_o;
    logic             act_rd_en_o;
    logic [VEC_W-1:0] act_rd_addr_o;
    logic             act_zero_o;
    logic             acc_en_o;
    logic             out_valid_o;
    logic [VEC_W-1:0] out_idx_o;

    modport slave (
        input  start_i, reload_w_i, num_vec_i,
        output busy_o, done_o, w_rd_en_o, w_rd_addr_o, load_en_o,
               act_rd_en_o, act_rd_addr_o, act_zero_o, acc_en_o,
               out_valid_o, out_idx_o
    );

    modport master (
        output start_i, reload_w_i, num_vec_i,
        input  busy_o, done_o, w_rd_en_o, w_rd_addr_o, load_en_o,
               act_rd_en_o, act_rd_addr_o, act_zero_o, acc_en_o,
               out_valid_o, out_idx_o
    );
endinterface

// File: rtl/ws_array_ctrl.sv
// Sequencer for an N x N weight-stationary systolic array: weight load, activation
// streaming, pipeline drain and result-vector flagging.
module ws_array_ctrl #(
    parameter int N        = 4,
    parameter int VEC_W    = 8,
    parameter int PIPE_LAT = 5
) (
    input  logic           clk,
    input  logic           rst,
    ws_array_ctrl_if.slave bus
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    // Shared phase counter must hold N, V-1 (VEC_W+1 bits) and PIPE_LAT-1 (<= 254).
    localparam int CW = (VEC_W + 1 > 9) ? VEC_W + 1 : 9;

    typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [VEC_W:0] v_q;
    logic [VEC_W:0] v_last;
    logic [CW-1:0]  dly_q;
    logic           dly_act_q;
    logic           out_vld_q;
    logic [VEC_W:0] out_idx_q;

    assign v_last = v_q - (VEC_W+1)'(1);

    always_comb begin
        state_d           = state_q;
        bus.busy_o        = 1'b0;
        bus.done_o        = 1'b0;
        bus.w_rd_en_o     = 1'b0;
        bus.w_rd_addr_o   = '0;
        bus.load_en_o     = '0;
        bus.act_rd_en_o   = 1'b0;
        bus.act_rd_addr_o = '0;
        bus.act_zero_o    = 1'b0;
        bus.acc_en_o      = 1'b0;
        bus.out_valid_o   = out_vld_q;
        bus.out_idx_o     = out_idx_q[VEC_W-1:0];
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    if (bus.reload_w_i)            state_d = LOAD_W;
                    else if (bus.num_vec_i != '0)  state_d = COMPUTE;
                    else                           state_d = DONE;
                end
            end
            LOAD_W: begin
                bus.busy_o = 1'b1;
                if (cnt_q < CW'(N)) begin
                    bus.w_rd_en_o   = 1'b1;
                    bus.w_rd_addr_o = cnt_q[AW-1:0];
                end
                // Row enable trails the read by one cycle to match SRAM latency.
                if (cnt_q != '0)
                    bus.load_en_o = N'(1) << (cnt_q - CW'(1));
                if (cnt_q == CW'(N))
                    state_d = (v_q != '0) ? COMPUTE : DONE;
            end
            COMPUTE: begin
                bus.busy_o        = 1'b1;
                bus.act_rd_en_o   = 1'b1;
                bus.act_rd_addr_o = cnt_q[VEC_W-1:0];
                bus.acc_en_o      = 1'b1;
                if (cnt_q == CW'(v_last))
                    state_d = DRAIN;
            end
            DRAIN: begin
                bus.busy_o     = 1'b1;
                bus.act_zero_o = 1'b1;
                bus.acc_en_o   = 1'b1;
                if (cnt_q == CW'(PIPE_LAT - 1))
                    state_d = DONE;
            end
            DONE: begin
                bus.busy_o = 1'b1;
                bus.done_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            v_q       <= '0;
            dly_q     <= '0;
            dly_act_q <= 1'b0;
            out_vld_q <= 1'b0;
            out_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || state_q == IDLE)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CW'(1);

            if (state_q == IDLE && bus.start_i)
                v_q <= {1'b0, bus.num_vec_i};

            // Result tracker runs independently of the state so it spans COMPUTE and DRAIN.
            if (state_q == COMPUTE && cnt_q == '0) begin
                dly_q     <= CW'(PIPE_LAT - 1);
                dly_act_q <= 1'b1;
            end else if (dly_act_q) begin
                dly_q <= dly_q - CW'(1);
                if (dly_q == CW'(1)) begin
                    dly_act_q <= 1'b0;
                    out_vld_q <= 1'b1;
                    out_idx_q <= '0;
                end
            end

            if (out_vld_q) begin
                if (out_idx_q == v_last) begin
                    out_vld_q <= 1'b0;
                    out_idx_q <= '0;
                end else begin
                    out_idx_q <= out_idx_q + (VEC_W+1)'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ws_array_ctrl.sv
// Directed bench for ws_array_ctrl: per-cycle output vectors against a cycle-schedule model.
module tb_ws_array_ctrl;
    localparam int N     = 4;
    localparam int VEC_W = 4;
    localparam int PL    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ws_array_ctrl_if #(.N(N), .VEC_W(VEC_W)) bus ();

    ws_array_ctrl #(.N(N), .VEC_W(VEC_W), .PIPE_LAT(PL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {busy, done, w_rd_en, w_rd_addr[1:0], load_en[3:0], act_rd_en, act_rd_addr[3:0],
    //  act_zero, acc_en, out_valid, out_idx[3:0]}
    function automatic logic [20:0] snap();
        return {bus.busy_o, bus.done_o, bus.w_rd_en_o, bus.w_rd_addr_o, bus.load_en_o,
                bus.act_rd_en_o, bus.act_rd_addr_o, bus.act_zero_o, bus.acc_en_o,
                bus.out_valid_o, bus.out_idx_o};
    endfunction

    function automatic int done_cyc(input bit r, input int v);
        int cs;
        cs = 1 + (r ? N + 1 : 0);
        return (v > 0) ? cs + v + PL : cs;
    endfunction

    // Expected outputs in cycle c after a start accepted in cycle 0.
    function automatic logic [20:0] exp_out(input int c, input bit r, input int v);
        int cs, ds, dn, os;
        logic busy, done, wen, aen, az, acc, ov;
        logic [1:0] wa;
        logic [3:0] le, aa, oi;
        cs   = 1 + (r ? N + 1 : 0);
        ds   = cs + v;
        dn   = done_cyc(r, v);
        os   = cs + PL;
        busy = (c >= 1 && c <= dn);
        done = (c == dn);
        wen  = r && c >= 1 && c <= N;
        wa   = wen ? 2'(c - 1) : 2'd0;
        le   = (r && c >= 2 && c <= N + 1) ? 4'(1 << (c - 2)) : 4'd0;
        aen  = (c >= cs && c < ds);
        aa   = aen ? 4'(c - cs) : 4'd0;
        az   = (v > 0 && c >= ds && c < ds + PL);
        acc  = aen || az;
        ov   = (c >= os && c < os + v);
        oi   = ov ? 4'(c - os) : 4'd0;
        return {busy, done, wen, wa, le, aen, aa, az, acc, ov, oi};
    endfunction

    // Issues start in the current cycle and checks cycles 1..ncyc; with noise, foreign
    // start pulses land in LOAD_W/COMPUTE and in DONE.
    task automatic run_op(input bit r, input int v, input int ncyc, input bit noise, input string tag);
        int dn;
        dn = done_cyc(r, v);
        bus.start_i    = 1'b1;
        bus.reload_w_i = r;
        bus.num_vec_i  = VEC_W'(v);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            bus.start_i    = 1'b0;
            bus.reload_w_i = 1'b0;
            bus.num_vec_i  = '0;
            check($sformatf("%s c=%0d", tag, c), 32'(snap()), 32'(exp_out(c, r, v)));
            if (noise && (c == 2 || c == N + 3 || c == dn)) begin
                bus.start_i    = 1'b1;
                bus.reload_w_i = ~r;
                bus.num_vec_i  = VEC_W'(v + 1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("mutex_rd", 32'(bus.w_rd_en_o & bus.act_rd_en_o), 32'd0);
            check("mutex_ld", 32'((|bus.load_en_o) & bus.acc_en_o), 32'd0);
        end
    end

    initial begin
        bus.start_i    = 1'b0;
        bus.reload_w_i = 1'b0;
        bus.num_vec_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(snap()), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(1'b1, 3, 16, 1'b0, "full");
        run_op(1'b0, 2, 10, 1'b0, "reuse");
        run_op(1'b0, 0, 4, 1'b0, "zero_v");
        run_op(1'b1, 3, 15, 1'b1, "ignore");
        run_op(1'b0, 2, 10, 1'b0, "b2b");
        run_op(1'b1, 15, 28, 1'b0, "max_v");

        bus.start_i    = 1'b1;
        bus.reload_w_i = 1'b0;
        bus.num_vec_i  = 4'd5;
        @(posedge clk); #1;
        bus.start_i    = 1'b0;
        bus.num_vec_i  = '0;
        check("pre_rst c=1", 32'(snap()), 32'(exp_out(1, 1'b0, 5)));
        @(posedge clk); #1;
        check("pre_rst c=2", 32'(snap()), 32'(exp_out(2, 1'b0, 5)));
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("rst_hold k=%0d", k), 32'(snap()), 32'd0);
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst k=%0d", k), 32'(snap()), 32'd0);
        end

        run_op(1'b0, 1, 9, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
